// File: rtl/gray_code_converter_stream.sv
// Registered binary<->Gray converter with a valid/ready stream and one output stage.
// Define GRAY_STEP_CHECK_EN to build the Gray-step checker that drives Step_Error.
module gray_code_converter_stream #(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic             Mode_In,
   input  logic [WIDTH-1:0] Data_In,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] Data_Out,
   output logic             Mode_Out,
   output logic             Step_Error
);

   logic [WIDTH-1:0] b2g;
   logic [WIDTH-1:0] g2b;
   logic [WIDTH-1:0] conv;
   logic             in_xfer;
   logic             step_err_new;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             mode_q, mode_d;
   logic             step_err_q, step_err_d;

   assign b2g[WIDTH-1] = Data_In[WIDTH-1];
   assign g2b[WIDTH-1] = Data_In[WIDTH-1];

   // Each binary bit is the XOR of all Gray bits at or above it, so no ripple chain is needed.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_conv
         assign b2g[gi] = Data_In[gi+1] ^ Data_In[gi];
         assign g2b[gi] = ^Data_In[WIDTH-1:gi];
      end
   endgenerate

   assign conv     = Mode_In ? g2b : b2g;
   assign In_Ready = !out_valid_q || Out_Ready;
   assign in_xfer  = In_Valid && In_Ready;

`ifdef GRAY_STEP_CHECK_EN
   logic             hist_valid_q, hist_valid_d;
   logic             hist_mode_q, hist_mode_d;
   logic [WIDTH-1:0] hist_gray_q, hist_gray_d;
   logic [WIDTH-1:0] gray_cur;
   logic [WIDTH-1:0] gray_diff;
   logic             one_bit_step;

   assign gray_cur     = Mode_In ? Data_In : b2g;
   assign gray_diff    = gray_cur ^ hist_gray_q;
   assign one_bit_step = (gray_diff != '0) && ((gray_diff & (gray_diff - 1'b1)) == '0);
   assign step_err_new = hist_valid_q && (Mode_In == hist_mode_q) && !one_bit_step;

   always_comb begin
      hist_valid_d = hist_valid_q;
      hist_mode_d  = hist_mode_q;
      hist_gray_d  = hist_gray_q;
      if (in_xfer) begin
         hist_valid_d = 1'b1;
         hist_mode_d  = Mode_In;
         hist_gray_d  = gray_cur;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         hist_valid_q <= 1'b0;
         hist_mode_q  <= 1'b0;
         hist_gray_q  <= '0;
      end else begin
         hist_valid_q <= hist_valid_d;
         hist_mode_q  <= hist_mode_d;
         hist_gray_q  <= hist_gray_d;
      end
   end
`else
   assign step_err_new = 1'b0;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      data_d      = data_q;
      mode_d      = mode_q;
      step_err_d  = step_err_q;
      if (in_xfer) begin
         out_valid_d = 1'b1;
         data_d      = conv;
         mode_d      = Mode_In;
         step_err_d  = step_err_new;
      end else if (Out_Ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         mode_q      <= 1'b0;
         step_err_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         mode_q      <= mode_d;
         step_err_q  <= step_err_d;
      end
   end

   assign Out_Valid  = out_valid_q;
   assign Data_Out   = data_q;
   assign Mode_Out   = mode_q;
   assign Step_Error = step_err_q;

endmodule

// File: tb/tb_gray_code_converter_stream.sv
// Bench for gray_code_converter_stream: directed scenarios plus random traffic
// checked against an arithmetic Gray/binary model with a word queue.
module tb_gray_code_converter_stream;
   localparam int W = 4;
`ifdef GRAY_STEP_CHECK_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic         Clock = 1'b0;
   logic         Reset_n = 1'b0;
   logic         In_Valid = 1'b0;
   logic         In_Ready;
   logic         Mode_In = 1'b0;
   logic [W-1:0] Data_In = '0;
   logic         Out_Valid;
   logic         Out_Ready = 1'b1;
   logic [W-1:0] Data_Out;
   logic         Mode_Out;
   logic         Step_Error;

   gray_code_converter_stream #(.WIDTH(W)) dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .Mode_In(Mode_In), .Data_In(Data_In),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Data_Out(Data_Out),
      .Mode_Out(Mode_Out), .Step_Error(Step_Error)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = '0;
      for (int k = 0; k < W; k++) b ^= (g >> k);
      return b;
   endfunction

   typedef struct {
      logic [W-1:0] d;
      logic         m;
      logic         e;
   } exp_t;

   exp_t         sb[$];
   logic         exp_ov = 1'b0;
   logic         hv = 1'b0;
   logic         hm = 1'b0;
   logic [W-1:0] hg = '0;

   // Scoreboard: outputs are compared in order against words the model predicted at acceptance.
   always @(negedge Clock) begin
      exp_t         e;
      exp_t         o;
      logic [W-1:0] g;
      if (!Reset_n) begin
         sb.delete();
         exp_ov = 1'b0;
         hv = 1'b0;
         chk("rst_out_valid", Out_Valid, 0);
      end else begin
         chk("in_ready", In_Ready, !Out_Valid || Out_Ready);
         chk("out_valid", Out_Valid, exp_ov);
         if (Out_Valid && Out_Ready) begin
            chk("q_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               o = sb.pop_front();
               $display("out: data=%0h mode=%0d err=%0d exp=%0h/%0d/%0d",
                        Data_Out, Mode_Out, Step_Error, o.d, o.m, o.e);
               chk("data_out", Data_Out, o.d);
               chk("mode_out", Mode_Out, o.m);
               chk("step_error", Step_Error, o.e);
            end
         end
         if (In_Valid && In_Ready) begin
            e.d = Mode_In ? from_gray(Data_In) : to_gray(Data_In);
            e.m = Mode_In;
            g = Mode_In ? Data_In : to_gray(Data_In);
            e.e = STEP_EN && hv && (Mode_In == hm) && ($countones(g ^ hg) != 1);
            hv = 1'b1;
            hm = Mode_In;
            hg = g;
            sb.push_back(e);
         end
         if (In_Valid && In_Ready) exp_ov = 1'b1;
         else if (Out_Valid && Out_Ready) exp_ov = 1'b0;
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic m);
      int   n;
      logic ok;
      In_Valid = 1'b1;
      Data_In  = d;
      Mode_In  = m;
      n = 0;
      do begin
         @(negedge Clock);
         ok = In_Ready;
         tick();
         n++;
      end while (!ok && n < 50);
      chk("send_accept", ok, 1);
   endtask

   task automatic idle();
      In_Valid = 1'b0;
      tick();
   endtask

   logic [W-1:0] b2g_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
   logic [W-1:0] g_in   [4] = '{4'h8, 4'h9, 4'hB, 4'hA};
   logic [W-1:0] g_exp  [4] = '{4'hF, 4'hE, 4'hD, 4'hC};
   logic [W-1:0] st_in  [4] = '{4'h3, 4'h4, 4'h4, 4'h9};
   logic         st_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      #2;
      chk("reset_valid", Out_Valid, 0);
      chk("reset_data", Data_Out, 0);
      chk("reset_mode", Mode_Out, 0);
      chk("reset_err", Step_Error, 0);
      #10 Reset_n = 1'b1;
      #1 chk("ready_after_reset", In_Ready, 1);
      tick();

      for (int k = 0; k < 16; k++) begin
         send(k[W-1:0], 1'b0);
         chk("b2g_valid", Out_Valid, 1);
         chk("b2g_table", Data_Out, b2g_tbl[k]);
      end
      for (int k = 0; k < 4; k++) begin
         send(g_in[k], 1'b1);
         chk("g2b_table", Data_Out, g_exp[k]);
         chk("g2b_mode", Mode_Out, 1);
      end
      idle();

      Out_Ready = 1'b0;
      send(4'h5, 1'b0);
      chk("stall_first", Data_Out, 4'h7);
      Data_In = 4'h3;
      Mode_In = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clock);
         chk("stall_ready", In_Ready, 0);
         chk("stall_data", Data_Out, 4'h7);
         chk("stall_valid", Out_Valid, 1);
         tick();
      end
      Out_Ready = 1'b1;
      @(negedge Clock);
      chk("release_ready", In_Ready, 1);
      tick();
      chk("release_next", Data_Out, 4'h2);
      chk("release_valid", Out_Valid, 1);

      send(4'h6, 1'b0);
      chk("alt_data0", Data_Out, 4'h5);
      chk("alt_mode0", Mode_Out, 0);
      send(4'h6, 1'b1);
      chk("alt_data1", Data_Out, 4'h4);
      chk("alt_mode1", Mode_Out, 1);

      send(4'hA, 1'b0);
      In_Valid  = 1'b0;
      Out_Ready = 1'b0;
      @(posedge Clock);
      #3;
      chk("pre_reset_valid", Out_Valid, 1);
      Reset_n = 1'b0;
      #1;
      chk("midreset_valid", Out_Valid, 0);
      chk("midreset_data", Data_Out, 0);
      chk("midreset_mode", Mode_Out, 0);
      @(negedge Clock);
      #2 Reset_n = 1'b1;
      Out_Ready = 1'b1;
      #1 chk("ready_after_midreset", In_Ready, 1);
      tick();

      for (int k = 0; k < 4; k++) begin
         send(st_in[k], 1'b0);
         chk("step_seq", Step_Error, STEP_EN ? st_exp[k] : 1'b0);
      end

      for (int c = 0; c < 400; c++) begin
         In_Valid  = ($urandom % 4) != 0;
         Data_In   = W'($urandom_range(0, (1 << W) - 1));
         Mode_In   = ($urandom % 5) == 0;
         Out_Ready = ($urandom % 3) != 0;
         tick();
      end

      In_Valid  = 1'b0;
      Out_Ready = 1'b1;
      repeat (3) tick();
      chk("drain_empty", sb.size(), 0);
      chk("drain_valid", Out_Valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end
endmodule
